event_counter: RTL and testbench
================================

# event_counter

Parametrised up/down event counter, successor to the fixed 16-bit push-to-count counter. It counts rising edges of asynchronous `inc`/`dec` strobes (buttons, external pulses), which are synchronised into the `clk` domain rather than used as clocks. Width, modulus and wrap/saturate mode are configurable, and the block adds synchronous load and a terminal-count pulse. It sits between debounced board inputs and display/decoder logic.

## Interface
- `WIDTH`, 16: counter width in bits, 2..32.
- `MAX_COUNT`, 2**WIDTH-1: highest count value; must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.
- `WRAP`, 1: 1 = modulo (MAX_COUNT+1) wrap; 0 = saturate at 0 and MAX_COUNT.
- `SYNC_STAGES`, 2: synchroniser depth for `inc`/`dec`, 2..4.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inc` in 1: asynchronous count-up strobe; each rising edge = one step.
- `dec` in 1: asynchronous count-down strobe; each rising edge = one step.
- `load` in 1: synchronous load enable, sampled on `clk`.
- `load_value` in WIDTH: value loaded when `load`=1.
- `count` out WIDTH: current count, registered.
- `tc` out 1: one-cycle pulse on wrap or on an attempted step past a limit.
- `at_max` out 1: `count` == MAX_COUNT, combinational from `count`.
- `at_zero` out 1: `count` == 0, combinational from `count`.

## Operation
- Reset (asynchronous, active-high) sets `count`=0, `tc`=0, all synchroniser and edge flops to 0. Reset outputs are therefore `at_zero`=1, and `at_max`=0 unless MAX_COUNT=0, which is illegal.
- Each strobe passes through a SYNC_STAGES flop chain, then a rising-edge detector producing a one-cycle `up_ev`/`dn_ev`.
- Priority per cycle: `load` > (`up_ev` xor `dn_ev`) > hold.
- `load`: `count` ← min(`load_value`, MAX_COUNT). A clamped value is not an error, so `tc`=0. Any coincident events are discarded, not deferred.
- `up_ev` and `dn_ev` in the same cycle: they cancel, so `count` holds and `tc`=0.
- Up step: if `count` < MAX_COUNT then +1. At MAX_COUNT: WRAP=1 gives `count`←0 with `tc`=1; WRAP=0 holds with `tc`=1.
- Down step: if `count` > 0 then −1. At 0: WRAP=1 gives `count`←MAX_COUNT with `tc`=1; WRAP=0 holds with `tc`=1.
- Arithmetic is WIDTH bits with explicit limit compares. Natural 2**WIDTH overflow is never relied on, so non-power-of-two MAX_COUNT behaves identically.
- `tc` is registered and high only in the cycle after the stepping edge, aligned with the new `count`.
- A strobe held high produces exactly one step. A new step needs a low period of at least one `clk` cycle after synchronisation.
- `inc` high across reset release produces exactly one up step, because the synchroniser resets to 0.

## Timing
- Latency from `inc`/`dec` rising edge to `count` update: SYNC_STAGES+1 rising `clk` edges, ±1 cycle of metastability uncertainty.
- `load`: `count` updates on the first `clk` edge where `load`=1 (latency 1).
- Maximum event rate: one step per 2 `clk` cycles per strobe.
- Reset assertion clears outputs immediately, with no clock required. If reset arrives mid-synchronisation, the in-flight edge is lost.

## Structure
- Package `event_counter_pkg` holds the `WRAP_MODE`/`SAT_MODE` localparam constants and a `clamp` function that returns min(value, limit).
- Sub-module `sync_edge_detect` (parameter `SYNC_STAGES`; ports `clk`, `reset`, `din`, `rise`) is instantiated twice, once for `inc` and once for `dec`.
- The top level contains the priority mux, the limit compares and the `tc` register.

## Test plan
All scenarios use WIDTH=4, MAX_COUNT=9, SYNC_STAGES=2.
- Reset then 10 `inc` pulses, WRAP=1 → `count` 1..9 then 0. `tc`=1 exactly once, in the cycle `count` becomes 0. Each step lands 3 cycles after its edge.
- WRAP=0, `load`=1 with `load_value`=15 → `count`=9, `at_max`=1, `tc`=0. A further `inc` leaves `count`=9 with `tc`=1. Then 10 `dec` pulses → `count` reaches 0, and the final pulse holds 0 with `tc`=1.
- WRAP=1 from 0, one `dec` → `count`=9, `tc`=1.
- `inc` and `dec` edges aligned to the same `clk` cycle with `count`=5 → `count` stays 5, `tc`=0. The same events coincident with `load`=1 and `load_value`=2 → `count`=2.
- `inc` held high for 50 cycles → exactly one step. `inc` high while `reset` deasserts → `count`=1 three cycles after release.
- With `count`=7, assert `reset` asynchronously mid-cycle → `count`=0 and `tc`=0 immediately. An `inc` edge 1 cycle before reset → no step after release.

Source files
------------

// File: rtl/event_counter_pkg.sv
// Shared constants and helpers for the up/down event counter.
package event_counter_pkg;

   localparam bit WRAP_MODE = 1'b1;
   localparam bit SAT_MODE  = 1'b0;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } op_e;

   function automatic logic [31:0] clamp(input logic [31:0] value,
                                         input logic [31:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous strobe into clk and emits a one-cycle pulse on its rising edge.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/event_counter.sv
// Up/down event counter: synchronised inc/dec strobes, synchronous load,
// wrap or saturate at 0 / MAX_COUNT, registered terminal-count pulse.
module event_counter
   import event_counter_pkg::*;
#(
   parameter int              WIDTH       = 16,
   parameter longint unsigned MAX_COUNT   = (64'd1 << WIDTH) - 64'd1,
   parameter bit              WRAP        = WRAP_MODE,
   parameter int              SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_zero
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_COUNT);

   logic             up_ev;
   logic             dn_ev;
   op_e              op;
   logic [WIDTH-1:0] count_d;
   logic             tc_d;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
      .clk   (clk),
      .reset (reset),
      .din   (inc),
      .rise  (up_ev)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_dec_sync (
      .clk   (clk),
      .reset (reset),
      .din   (dec),
      .rise  (dn_ev)
   );

   // Load wins outright; simultaneous up and down events cancel.
   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (up_ev ^ dn_ev) begin
         op = up_ev ? OP_UP : OP_DOWN;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      count_d = count;
      tc_d    = 1'b0;
      unique case (op)
         OP_LOAD: count_d = WIDTH'(clamp(32'(load_value), 32'(LIMIT)));
         OP_UP: begin
            if (count < LIMIT) begin
               count_d = count + WIDTH'(1);
            end else begin
               tc_d = 1'b1;
               if (WRAP == WRAP_MODE) count_d = '0;
            end
         end
         OP_DOWN: begin
            if (count > '0) begin
               count_d = count - WIDTH'(1);
            end else begin
               tc_d = 1'b1;
               if (WRAP == WRAP_MODE) count_d = LIMIT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= count_d;
         tc    <= tc_d;
      end
   end

   assign at_max  = (count == LIMIT);
   assign at_zero = (count == '0);

endmodule

// File: tb/tb_event_counter.sv
// Scoreboard bench: a wrapping and a saturating counter (WIDTH=4, MAX_COUNT=9) share one stimulus.
module tb_event_counter;

   localparam int W    = 4;
   localparam int MAXC = 9;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic         inc, dec, load;
   logic [W-1:0] load_value;
   logic [W-1:0] count_w, count_s;
   logic         tc_w, tc_s, at_max_w, at_max_s, at_zero_w, at_zero_s;

   event_counter #(.WIDTH(W), .MAX_COUNT(MAXC), .WRAP(1'b1), .SYNC_STAGES(2)) dut_w (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load), .load_value(load_value),
      .count(count_w), .tc(tc_w), .at_max(at_max_w), .at_zero(at_zero_w)
   );

   event_counter #(.WIDTH(W), .MAX_COUNT(MAXC), .WRAP(1'b0), .SYNC_STAGES(2)) dut_s (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .load(load), .load_value(load_value),
      .count(count_s), .tc(tc_s), .at_max(at_max_s), .at_zero(at_zero_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int cnt_w;
      int cnt_s;
      bit tc_w;
      bit tc_s;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;
   int   mc_w     = 0;
   int   mc_s     = 0;
   int   cur_w    = 0;
   int   cur_s    = 0;
   bit   et_w, et_s;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void step_model(input int c, input bit wrap, input bit up,
                                      output int n, output bit t);
      n = c;
      t = 1'b0;
      if (up) begin
         if (c < MAXC) n = c + 1;
         else begin t = 1'b1; n = wrap ? 0 : MAXC; end
      end else begin
         if (c > 0) n = c - 1;
         else begin t = 1'b1; n = wrap ? MAXC : 0; end
      end
   endfunction

   task automatic sched(input bit up, input bit dn, input int due);
      exp_t x;
      int   nw, ns;
      bit   tw, ts;
      x.due  = due;
      x.tc_w = 1'b0;
      x.tc_s = 1'b0;
      if (up != dn) begin
         step_model(mc_w, 1'b1, up, nw, tw);
         step_model(mc_s, 1'b0, up, ns, ts);
         mc_w = nw; mc_s = ns; x.tc_w = tw; x.tc_s = ts;
      end
      x.cnt_w = mc_w;
      x.cnt_s = mc_s;
      sb.push_back(x);
   endtask

   task automatic sched_load(input int v);
      exp_t x;
      mc_w    = (v > MAXC) ? MAXC : v;
      mc_s    = mc_w;
      x.due   = cyc + 1;
      x.cnt_w = mc_w;
      x.cnt_s = mc_s;
      x.tc_w  = 1'b0;
      x.tc_s  = 1'b0;
      sb.push_back(x);
   endtask

   // Every cycle: pop the entry due now (if any), otherwise expect a hold with tc low.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         cur_w = 0;
         cur_s = 0;
      end else if (mon_en) begin
         et_w = 1'b0;
         et_s = 1'b0;
         if (sb.size() != 0 && sb[0].due < cyc) begin
            check("sb_overdue", cyc, sb[0].due);
            void'(sb.pop_front());
         end
         if (sb.size() != 0 && sb[0].due == cyc) begin
            e     = sb.pop_front();
            cur_w = e.cnt_w;
            cur_s = e.cnt_s;
            et_w  = e.tc_w;
            et_s  = e.tc_s;
         end
         check("count_w",   int'(count_w),   cur_w);
         check("count_s",   int'(count_s),   cur_s);
         check("tc_w",      int'(tc_w),      int'(et_w));
         check("tc_s",      int'(tc_s),      int'(et_s));
         check("at_max_w",  int'(at_max_w),  int'(cur_w == MAXC));
         check("at_max_s",  int'(at_max_s),  int'(cur_s == MAXC));
         check("at_zero_w", int'(at_zero_w), int'(cur_w == 0));
         check("at_zero_s", int'(at_zero_s), int'(cur_s == 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit up, input bit dn);
      inc = up;
      dec = dn;
      sched(up, dn, cyc + 3);
      tick();
      inc = 1'b0;
      dec = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_load(input int v);
      load       = 1'b1;
      load_value = W'(v);
      sched_load(v);
      tick();
      load = 1'b0;
      tick();
   endtask

   task automatic reset_pulse();
      mon_en = 1'b0;
      reset  = 1'b1;
      mc_w   = 0;
      mc_s   = 0;
      repeat (2) tick();
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = '0;
      #1 reset = 1'b1;
      #1;
      check("rst_count_w",   int'(count_w),   0);
      check("rst_count_s",   int'(count_s),   0);
      check("rst_tc_w",      int'(tc_w),      0);
      check("rst_at_zero_w", int'(at_zero_w), 1);
      check("rst_at_max_w",  int'(at_max_w),  0);
      repeat (2) tick();
      reset  = 1'b0;
      mon_en = 1'b1;

      for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
      check("ten_inc_w", int'(count_w), 0);
      check("ten_inc_s", int'(count_s), 9);

      do_load(15);
      check("load_clamp_s", int'(count_s),  9);
      check("load_atmax_s", int'(at_max_s), 1);
      pulse(1'b1, 1'b0);
      check("inc_at_max_s", int'(count_s), 9);
      check("inc_at_max_w", int'(count_w), 0);
      for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1);
      check("ten_dec_s", int'(count_s), 0);
      check("ten_dec_w", int'(count_w), 0);

      reset_pulse();
      pulse(1'b0, 1'b1);
      check("dec_zero_w", int'(count_w), 9);
      check("dec_zero_s", int'(count_s), 0);

      do_load(5);
      pulse(1'b1, 1'b1);
      check("cancel_w", int'(count_w), 5);

      inc = 1'b1; dec = 1'b1;
      tick();
      inc = 1'b0; dec = 1'b0;
      tick();
      do_load(2);
      check("load_over_both", int'(count_w), 2);

      inc = 1'b1;
      tick();
      inc = 1'b0;
      tick();
      do_load(7);
      check("load_over_inc", int'(count_w), 7);

      do_load(3);
      inc = 1'b1;
      sched(1'b1, 1'b0, cyc + 3);
      repeat (50) tick();
      inc = 1'b0;
      repeat (4) tick();
      check("held_one_step", int'(count_w), 4);

      mon_en = 1'b0;
      reset  = 1'b1;
      mc_w   = 0;
      mc_s   = 0;
      inc    = 1'b1;
      repeat (3) tick();
      reset  = 1'b0;
      mon_en = 1'b1;
      sched(1'b1, 1'b0, cyc + 3);
      repeat (2) tick();
      check("release_pre", int'(count_w), 0);
      tick();
      check("release_step", int'(count_w), 1);
      inc = 1'b0;
      repeat (3) tick();

      do_load(7);
      inc = 1'b1;
      tick();
      #2;
      mon_en = 1'b0;
      reset  = 1'b1;
      mc_w   = 0;
      mc_s   = 0;
      #1;
      check("async_count_w",   int'(count_w),   0);
      check("async_count_s",   int'(count_s),   0);
      check("async_tc_w",      int'(tc_w),      0);
      check("async_at_zero_w", int'(at_zero_w), 1);
      inc = 1'b0;
      repeat (2) tick();
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (6) tick();
      check("lost_edge_w", int'(count_w), 0);

      check("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
